// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types, register offsets and CTRL field positions for timer_counter
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

  // Word offsets decoded from addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PS_LO   = 4;
  localparam int CTRL_PS_HI   = 7;

  localparam int PS_W = CTRL_PS_HI - CTRL_PS_LO + 1;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Replace the byte lanes of old_val selected by be with the same lanes of new_val
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/tc_prescaler.sv
// rtl/tc_prescaler.sv - divides CNT-state cycles into count-down ticks every limit+1 cycles
module tc_prescaler
  import tc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            run,
  input  logic [PS_W-1:0] limit,
  output logic            tick
);

  logic [PS_W-1:0] cnt_q;
  logic [PS_W-1:0] cnt_d;

  assign tick = run && (cnt_q == limit);

  // Next prescale count: cleared outside counting, restarts after each tick
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescale count register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped countdown timer with interrupt; TC_PRESCALE_EN adds CTRL[7:4] prescaler
module timer_counter
  import tc_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

`ifdef TC_PRESCALE_EN
  localparam logic [7:0] CTRL_MASK = 8'hFF;
`else
  localparam logic [7:0] CTRL_MASK = 8'h0F;
`endif

  tc_state_e   state_q, state_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;

  logic [1:0]  sel;
  logic        we_ctrl;
  logic        we_preset;
  logic [7:0]  ctrl_wr;
  logic        en_eff;
  logic        tick;
  logic [27:0] unused_addr;

  // addr[1:0] of the word address carries byte address bits [3:2]
  assign sel         = addr[1:0];
  assign unused_addr = addr[29:2];
  assign we_ctrl     = (|byteen) && (sel == REG_CTRL);
  assign we_preset   = (|byteen) && (sel == REG_PRESET);
  // Only lane 0 of CTRL holds state; other lanes are reserved
  assign ctrl_wr     = byteen[0] ? (wdata[7:0] & CTRL_MASK) : ctrl_q;
  // A CTRL write that drops EN stops LOAD/CNT immediately
  assign en_eff      = we_ctrl ? ctrl_wr[CTRL_EN] : ctrl_q[CTRL_EN];
  assign irq         = irq_q;

`ifdef TC_PRESCALE_EN
  tc_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear ((state_q == IDLE) || (state_q == LOAD)),
    .run   (state_q == CNT),
    .limit (ctrl_q[CTRL_PS_HI:CTRL_PS_LO]),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Combinational register read mux
  always_comb begin
    rdata = 32'h0;
    case (sel)
      REG_CTRL:   rdata = {24'h0, ctrl_q};
      REG_PRESET: rdata = preset_q;
      REG_COUNT:  rdata = count_q;
      default:    rdata = 32'h0;
    endcase
  end

  // Bus writes first, then FSM next-state; a CTRL write beats the FSM's EN clear
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    state_d  = state_q;
    pend_d   = pend_q;

    if (we_ctrl) begin
      ctrl_d = ctrl_wr;
      pend_d = 1'b0;
    end
    if (we_preset) begin
      preset_d = byte_merge(preset_q, wdata, byteen);
    end

    case (state_q)
      IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = LOAD;
      end
      LOAD: begin
        if (!en_eff) begin
          state_d = IDLE;
        end else begin
          count_d = preset_q;
          state_d = CNT;
        end
      end
      CNT: begin
        if (!en_eff) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = 32'd0;
            pend_d  = 1'b1;
            state_d = INT;
          end
        end
      end
      INT: begin
        if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
          pend_d  = 1'b0;
          state_d = LOAD;
        end else begin
          if (!we_ctrl) ctrl_d[CTRL_EN] = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    irq_d = pend_d & ctrl_d[CTRL_IM];
  end

  // State and register file update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= 8'h0;
      preset_q <= RESET_PRESET;
      count_q  <= 32'h0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - self-checking bench for timer_counter
module tb_timer_counter;
  import tc_pkg::*;

  localparam logic [31:0] RP = 32'h1234_5678;
`ifdef TC_PRESCALE_EN
  localparam logic [31:0] CM = 32'hFF;
`else
  localparam logic [31:0] CM = 32'h0F;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  timer_counter #(.RESET_PRESET(RP)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  be;
    logic [31:0] d;
    logic [1:0]  rsel;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[10];

  function automatic void push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endfunction

  function automatic void push_ci(input string tag, input logic [31:0] c, input logic i);
    push({tag, "_count"}, c);
    push({tag, "_irq"}, {31'b0, i});
  endfunction

  task automatic pop_cmp(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s actual=%h expected=%h", e.tag, act, e.v);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [3:0] be, input logic [31:0] d);
    addr   = {28'h0, sel};
    byteen = be;
    wdata  = d;
    step();
    byteen = 4'h0;
  endtask

  task automatic rd(input logic [1:0] sel);
    addr = {28'h0, sel};
    #1;
    pop_cmp(rdata);
  endtask

  task automatic run_seq(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      rd(REG_COUNT);
      pop_cmp({31'b0, irq});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int ph;
    logic [31:0] c;

    reset = 1'b1; addr = '0; byteen = 4'h0; wdata = '0;
    step(); step();
    reset = 1'b0;

    // reset values of all four addresses and irq
    push("rst_ctrl", 32'h0); push("rst_preset", RP); push("rst_count", 32'h0); push("rst_rsvd", 32'h0);
    rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
    push("rst_irq", 32'h0); pop_cmp({31'b0, irq});

    // register access vectors
    vt[0] = '{REG_PRESET, 4'hF, 32'hAABB_CC00, REG_PRESET, 32'hAABB_CC00};
    vt[1] = '{REG_PRESET, 4'h1, 32'h0000_0007, REG_PRESET, 32'hAABB_CC07};
    vt[2] = '{REG_PRESET, 4'h0, 32'hFFFF_FFFF, REG_PRESET, 32'hAABB_CC07};
    vt[3] = '{REG_PRESET, 4'hC, 32'h1122_3344, REG_PRESET, 32'h1122_CC07};
    vt[4] = '{REG_COUNT,  4'hF, 32'hDEAD_BEEF, REG_COUNT,  32'h0};
    vt[5] = '{2'd3,       4'hF, 32'hFFFF_FFFF, 2'd3,       32'h0};
    vt[6] = '{REG_CTRL,   4'hF, 32'hFFFF_FF0E, REG_CTRL,   32'h0000_000E & CM | 32'h0};
    vt[7] = '{REG_CTRL,   4'h2, 32'h0000_FF00, REG_CTRL,   32'h0000_000E};
    vt[8] = '{REG_CTRL,   4'h1, 32'h0000_00F4, REG_CTRL,   32'h0000_00F4 & CM};
    vt[9] = '{REG_CTRL,   4'hF, 32'h0,         REG_CTRL,   32'h0};
    for (int i = 0; i < 10; i++) begin
      push($sformatf("vec%0d", i), vt[i].exp);
      wr(vt[i].sel, vt[i].be, vt[i].d);
      rd(vt[i].rsel);
    end

    // one-shot: PRESET=3, CTRL=EN|IM
    wr(REG_PRESET, 4'hF, 32'd3);
    wr(REG_CTRL, 4'hF, 32'h9);
    push_ci("A1", 0, 0); push_ci("A2", 3, 0); push_ci("A3", 2, 0);
    push_ci("A4", 1, 0); push_ci("A5", 0, 1); push_ci("A6", 0, 1);
    run_seq(6);
    push("A_ctrl_en_cleared", 32'h8); rd(REG_CTRL);
    step();
    push("A_irq_held", 32'h1); pop_cmp({31'b0, irq});
    wr(REG_CTRL, 4'hF, 32'h0);
    push("A_irq_dropped", 32'h0); pop_cmp({31'b0, irq});

    // auto-reload: PRESET=2, CTRL=EN|RELOAD|IM, five periods
    wr(REG_PRESET, 4'hF, 32'd2);
    wr(REG_CTRL, 4'hF, 32'hB);
    for (int k = 1; k <= 21; k++) begin
      if (k == 1) begin
        push_ci($sformatf("B%0d", k), 0, 0);
      end else begin
        ph = (k - 2) % 4;
        c  = (ph == 0) ? 32'd2 : (ph == 1) ? 32'd1 : 32'd0;
        push_ci($sformatf("B%0d", k), c, ph == 2);
      end
    end
    pulses = 0;
    for (int k = 1; k <= 21; k++) begin
      step();
      rd(REG_COUNT);
      if (irq) pulses++;
      pop_cmp({31'b0, irq});
    end
    push("B_pulses", 32'd5); pop_cmp(pulses);
    wr(REG_CTRL, 4'hF, 32'h0);

    // IM=0: FSM runs to completion, irq stays low
    wr(REG_PRESET, 4'hF, 32'd1);
    wr(REG_CTRL, 4'hF, 32'h1);
    push_ci("C1", 0, 0); push_ci("C2", 1, 0); push_ci("C3", 0, 0); push_ci("C4", 0, 0);
    run_seq(4);
    push("C_ctrl_en_cleared", 32'h0); rd(REG_CTRL);
    wr(REG_CTRL, 4'hF, 32'h0);

    // CTRL write in INT beats the FSM's EN clear and clears the pending irq
    wr(REG_CTRL, 4'hF, 32'h9);
    push_ci("W1", 0, 0); push_ci("W2", 1, 0); push_ci("W3", 0, 1);
    run_seq(3);
    wr(REG_CTRL, 4'hF, 32'h9);
    push("W_ctrl_kept", 32'h9); rd(REG_CTRL);
    push("W_irq_cleared", 32'h0); pop_cmp({31'b0, irq});
    push_ci("W5", 0, 0); push_ci("W6", 1, 0); push_ci("W7", 0, 1);
    run_seq(3);
    wr(REG_CTRL, 4'hF, 32'h0);

    // mid-count stop, PRESET write during CNT
    wr(REG_PRESET, 4'hF, 32'd10);
    wr(REG_CTRL, 4'hF, 32'h9);
    push_ci("D1", 0, 0); push_ci("D2", 10, 0); push_ci("D3", 9, 0);
    run_seq(3);
    wr(REG_PRESET, 4'hF, 32'd100);
    push("D4_count", 32'd8); rd(REG_COUNT);
    push_ci("D5", 7, 0); push_ci("D6", 6, 0); push_ci("D7", 5, 0);
    run_seq(3);
    wr(REG_CTRL, 4'hF, 32'h0);
    push_ci("D8", 5, 0); rd(REG_COUNT); pop_cmp({31'b0, irq});
    push_ci("D9", 5, 0); push_ci("D10", 5, 0);
    run_seq(2);
    wr(REG_CTRL, 4'hF, 32'h9);
    push_ci("D_restart1", 5, 0); push_ci("D_restart2", 100, 0);
    run_seq(2);
    wr(REG_CTRL, 4'hF, 32'h0);

    // PRESET=0 behaves like PRESET=1
    wr(REG_PRESET, 4'hF, 32'd0);
    wr(REG_CTRL, 4'hF, 32'h9);
    push_ci("E1", 100, 0); push_ci("E2", 0, 0); push_ci("E3", 0, 1);
    run_seq(3);
    wr(REG_CTRL, 4'hF, 32'h0);
    push("E_irq_dropped", 32'h0); pop_cmp({31'b0, irq});

`ifdef TC_PRESCALE_EN
    // PRESCALE=2, PRESET=2: each value held three cycles, irq at edge 8
    wr(REG_PRESET, 4'hF, 32'd2);
    wr(REG_CTRL, 4'hF, 32'h29);
    push_ci("P1", 0, 0);
    for (int k = 2; k <= 4; k++) push_ci($sformatf("P%0d", k), 2, 0);
    for (int k = 5; k <= 7; k++) push_ci($sformatf("P%0d", k), 1, 0);
    push_ci("P8", 0, 1);
    run_seq(8);
    wr(REG_CTRL, 4'hF, 32'h0);
`endif

    // reset mid-count overrides everything
    wr(REG_PRESET, 4'hF, 32'd50);
    wr(REG_CTRL, 4'hF, 32'h9);
    push_ci("R1", 0, 0); push_ci("R2", 50, 0); push_ci("R3", 49, 0); push_ci("R4", 48, 0);
    run_seq(4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    push("R_ctrl", 32'h0); push("R_preset", RP); push("R_count", 32'h0); push("R_rsvd", 32'h0);
    rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
    push("R_irq", 32'h0); pop_cmp({31'b0, irq});
    push_ci("R_idle", 0, 0);
    run_seq(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
